voting_ballot_collector: RTL and testbench

Upstream intake stage for the 8-voter, 1-bit voting circuit. It accepts single ballots (voter id + 1-bit vote) over a valid/ready stream and rejects duplicate ids. It assembles the 8-bit vote vector that drives the voter's `p_input` and holds it stable while the combinational voter settles. It then registers the voter's `o[0]` and returns it over a valid/ready result handshake before opening the next round.

---
 rtl/voting_ballot_collector.sv | 91 +++++++++
 tb/tb_voting_ballot_collector.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/voting_ballot_collector.sv
// Ballot intake for the 8-voter voting circuit: collects one vote per voter id,
// freezes the vote vector while the voter settles, then returns the registered result.
module voting_ballot_collector #(
  parameter int NVOTERS = 8,
  parameter int IDW     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ballot_valid,
  output logic               ballot_ready,
  input  logic [IDW-1:0]     ballot_id,
  input  logic               ballot_vote,
  input  logic               close,
  output logic [NVOTERS-1:0] p_input,
  input  logic               o_in,
  output logic [NVOTERS-1:0] voted_mask,
  output logic [IDW:0]       count,
  output logic               dup_err,
  output logic               result_valid,
  output logic               result,
  input  logic               result_ready
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EVAL    = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [IDW:0] LAST_COUNT = (IDW+1)'(NVOTERS - 1);

  state_t state;
  logic   accept;
  logic   is_dup;
  logic   fills_round;

  // Ready must fall in the very cycle reset is asserted, so it also looks at rst.
  assign ballot_ready = (state == COLLECT) && !rst;
  assign accept       = ballot_valid && ballot_ready;
  assign is_dup       = voted_mask[ballot_id];
  assign fills_round  = accept && !is_dup && (count == LAST_COUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= COLLECT;
      p_input      <= '0;
      voted_mask   <= '0;
      count        <= '0;
      dup_err      <= 1'b0;
      result_valid <= 1'b0;
      result       <= 1'b0;
    end else begin
      dup_err <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            if (is_dup) begin
              dup_err <= 1'b1;
            end else begin
              voted_mask[ballot_id] <= 1'b1;
              p_input[ballot_id]    <= ballot_vote;
              count                 <= count + 1'b1;
            end
          end
          // A ballot arriving together with close is still recorded above.
          if (close || fills_round) begin
            state <= EVAL;
          end
        end
        EVAL: begin
          result       <= o_in;
          result_valid <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            p_input      <= '0;
            voted_mask   <= '0;
            count        <= '0;
            state        <= COLLECT;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voting_ballot_collector.sv
// Self-checking bench for voting_ballot_collector: directed scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_voting_ballot_collector;

  localparam int NVOTERS = 8;
  localparam int IDW     = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               ballot_valid;
  logic               ballot_ready;
  logic [IDW-1:0]     ballot_id;
  logic               ballot_vote;
  logic               close;
  logic [NVOTERS-1:0] p_input;
  logic               o_in;
  logic [NVOTERS-1:0] voted_mask;
  logic [IDW:0]       count;
  logic               dup_err;
  logic               result_valid;
  logic               result;
  logic               result_ready;

  int checks = 0;
  int errors = 0;

  // Model of the round: per-voter vote/voted flags, ballot count, phase of the round.
  bit m_vote  [NVOTERS];
  bit m_voted [NVOTERS];
  int m_count;
  int m_phase;
  bit m_valid;
  bit m_result;
  bit m_dup;

  voting_ballot_collector #(.NVOTERS(NVOTERS), .IDW(IDW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ballot_valid (ballot_valid),
    .ballot_ready (ballot_ready),
    .ballot_id    (ballot_id),
    .ballot_vote  (ballot_vote),
    .close        (close),
    .p_input      (p_input),
    .o_in         (o_in),
    .voted_mask   (voted_mask),
    .count        (count),
    .dup_err      (dup_err),
    .result_valid (result_valid),
    .result       (result),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  // Stand-in for the external combinational voter: strict majority of eight.
  assign o_in = ($countones(p_input) >= 5);

  function automatic logic [NVOTERS-1:0] modelVotes();
    logic [NVOTERS-1:0] v = '0;
    for (int i = 0; i < NVOTERS; i++) v[i] = m_vote[i];
    return v;
  endfunction

  function automatic logic [NVOTERS-1:0] modelMask();
    logic [NVOTERS-1:0] v = '0;
    for (int i = 0; i < NVOTERS; i++) v[i] = m_voted[i];
    return v;
  endfunction

  function automatic bit modelMajority();
    int yes = 0;
    for (int i = 0; i < NVOTERS; i++) yes += m_vote[i];
    return (yes * 2 > NVOTERS);
  endfunction

  task automatic clearRound();
    for (int i = 0; i < NVOTERS; i++) begin
      m_vote[i]  = 1'b0;
      m_voted[i] = 1'b0;
    end
    m_count = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advances the model by one clock edge using the inputs seen during that cycle.
  task automatic modelStep(input logic r, input logic bv, input logic [IDW-1:0] id,
                           input logic v, input logic cl, input logic rr);
    m_dup = 1'b0;
    if (r) begin
      clearRound();
      m_phase  = 0;
      m_valid  = 1'b0;
      m_result = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          if (bv) begin
            if (m_voted[id]) begin
              m_dup = 1'b1;
            end else begin
              m_voted[id] = 1'b1;
              m_vote[id]  = v;
              m_count++;
            end
          end
          if (cl || m_count == NVOTERS) m_phase = 1;
        end
        1: begin
          m_result = modelMajority();
          m_valid  = 1'b1;
          m_phase  = 2;
        end
        default: begin
          if (rr) begin
            clearRound();
            m_valid = 1'b0;
            m_phase = 0;
          end
        end
      endcase
    end
  endtask

  // Drives one cycle of inputs (called just after a rising edge) and checks the results.
  task automatic applyStimulus(input logic r, input logic bv, input logic [IDW-1:0] id,
                               input logic v, input logic cl, input logic rr);
    rst          = r;
    ballot_valid = bv;
    ballot_id    = id;
    ballot_vote  = v;
    close        = cl;
    result_ready = rr;
    #1;
    checkOutput("ballot_ready", 32'(ballot_ready), 32'(m_phase == 0 && !r));
    @(posedge clk);
    modelStep(r, bv, id, v, cl, rr);
    #1;
    checkOutput("p_input", 32'(p_input), 32'(modelVotes()));
    checkOutput("voted_mask", 32'(voted_mask), 32'(modelMask()));
    checkOutput("count", 32'(count), 32'(m_count));
    checkOutput("dup_err", 32'(dup_err), 32'(m_dup));
    checkOutput("result_valid", 32'(result_valid), 32'(m_valid));
    checkOutput("result", 32'(result), 32'(m_result));
  endtask

  task automatic ballot(input logic [IDW-1:0] id, input logic v);
    applyStimulus(1'b0, 1'b1, id, v, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rr);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, rr);
  endtask

  initial begin
    logic [7:0] votes_a;
    clearRound();
    m_phase = 0; m_valid = 0; m_result = 0; m_dup = 0;

    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_valid", 32'(result_valid), 32'h0);
    checkOutput("reset_p", 32'(p_input), 32'h0);

    // Full round: ids 0..7 with votes 1,0,1,1,0,0,1,0
    votes_a = 8'b0100_1101;
    for (int i = 0; i < NVOTERS; i++) ballot(IDW'(i), votes_a[i]);
    checkOutput("full_p", 32'(p_input), 32'h4D);
    checkOutput("full_mask", 32'(voted_mask), 32'hFF);
    checkOutput("full_count", 32'(count), 32'd8);
    idle(1'b0);
    checkOutput("full_valid", 32'(result_valid), 32'h1);
    checkOutput("full_result", 32'(result), 32'h0);
    // Back-pressure for 20 cycles
    for (int i = 0; i < 20; i++) idle(1'b0);
    checkOutput("hold_p", 32'(p_input), 32'h4D);
    idle(1'b1);
    checkOutput("after_hs_count", 32'(count), 32'h0);

    // Duplicate id 3
    ballot(3'd3, 1'b1);
    ballot(3'd3, 1'b0);
    checkOutput("dup_pulse", 32'(dup_err), 32'h1);
    checkOutput("dup_p3", 32'(p_input[3]), 32'h1);
    checkOutput("dup_count", 32'(count), 32'h1);
    idle(1'b0);
    checkOutput("dup_once", 32'(dup_err), 32'h0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // Ids 0 and 5, then close
    ballot(3'd0, 1'b1);
    ballot(3'd5, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("close_p", 32'(p_input), 32'h21);
    checkOutput("close_valid_early", 32'(result_valid), 32'h0);
    idle(1'b0);
    checkOutput("close_valid", 32'(result_valid), 32'h1);
    checkOutput("close_mask", 32'(voted_mask), 32'h21);
    idle(1'b1);

    // Close together with a ballot for id 2
    applyStimulus(1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0);
    checkOutput("concur_p", 32'(p_input), 32'h04);
    checkOutput("concur_count", 32'(count), 32'h1);
    idle(1'b0);
    idle(1'b0);
    // Reset while in HOLD abandons the round
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_hold_valid", 32'(result_valid), 32'h0);
    checkOutput("rst_hold_p", 32'(p_input), 32'h0);
    checkOutput("rst_hold_count", 32'(count), 32'h0);
    for (int i = 0; i < NVOTERS; i++) ballot(IDW'(7 - i), 1'b1);
    idle(1'b0);
    checkOutput("rerun_result", 32'(result), 32'h1);
    idle(1'b1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 249) == 0),
                    ($urandom_range(0, 9) < 7),
                    IDW'($urandom_range(0, NVOTERS - 1)),
                    1'($urandom),
                    ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
